pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/mux2.sv | 18 +
 rtl/pc_adder.sv | 13 +
 rtl/pc_fetch_unit.sv | 121 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, the canonical NOP word
// and the default boot address.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR            = 32'h00000013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h00000000;

  // Instruction fetches must land on a 4-byte boundary.
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/mux2.sv
// Generic 2:1 mux: sel = 0 passes in_1, sel = 1 passes in_2.
module mux2 #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_1,
  input  logic [W-1:0] in_2,
  input  logic         sel,
  output logic [W-1:0] out
);

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      assign out[gi] = sel ? in_2[gi] : in_1[gi];
    end
  endgenerate

endmodule

// File: rtl/pc_adder.sv
// Sequential-PC adder; wraps modulo 2^W with no carry out.
module pc_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] pc,
  output logic [W-1:0] pc_plus4
);

  localparam logic [W-1:0] STEP = W'(4);

  assign pc_plus4 = pc + STEP;

endmodule

// File: rtl/pc_fetch_unit.sv
// Single-outstanding instruction fetch stage: BOOT -> FETCH <-> EXEC, with a
// sticky HALT on a misaligned jump/branch target.
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int          XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] target_addr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned_err
);

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] instr_reg, instr_next;
  logic            valid_reg, valid_next;
  logic            err_reg, err_next;
  logic            req_comb;
  logic [XLEN-1:0] sel_addr;

  pc_adder #(.W(XLEN)) u_pc_adder (
    .pc       (pc_reg),
    .pc_plus4 (pc_plus4)
  );

  mux2 #(.W(XLEN)) u_next_pc_mux (
    .in_1 (pc_plus4),
    .in_2 (target_addr),
    .sel  (pc_sel),
    .out  (sel_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg    <= RESET_VECTOR;
      instr_reg <= NOP_INSTR;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    valid_next = valid_reg;
    err_next   = err_reg;
    req_comb   = 1'b0;

    case (state_reg)
      ST_BOOT: begin
        state_next = ST_FETCH;
      end

      ST_FETCH: begin
        req_comb = 1'b1;
        if (imem_ready) begin
          instr_next = imem_rdata;
          valid_next = 1'b1;
          state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (!stall_i) begin
          valid_next = 1'b0;
          // A misaligned taken target freezes the PC so it still names the
          // instruction that caused the fault.
          if (pc_sel && !is_word_aligned(target_addr[1:0])) begin
            err_next   = 1'b1;
            state_next = ST_HALT;
          end else begin
            pc_next    = sel_addr;
            state_next = ST_FETCH;
          end
        end
      end

      ST_HALT: begin
        valid_next = 1'b0;
      end

      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  assign imem_req       = req_comb;
  assign imem_addr      = pc_reg;
  assign pc_out         = pc_reg;
  assign instr_out      = instr_reg;
  assign instr_valid    = valid_reg;
  assign misaligned_err = err_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios with literal expectations plus a
// long randomized run, all checked every cycle against a behavioural model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RV  = 32'h00000000;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        pc_sel;
  logic [31:0] target_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        misaligned_err;

  int total = 0;
  int bad   = 0;
  bit check_en = 0;

  pc_fetch_unit #(.RESET_VECTOR(RV), .XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .pc_sel         (pc_sel),
    .target_addr    (target_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .pc_plus4       (pc_plus4),
    .misaligned_err (misaligned_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: the unit either waits one boot cycle, waits for memory,
  // holds a valid instruction, or is dead after a misaligned target.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  bit          m_have;
  bit          m_boot;
  bit          m_halt;
  bit          m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc    <= RV;
      m_instr <= NOP;
      m_have  <= 0;
      m_boot  <= 1;
      m_halt  <= 0;
      m_err   <= 0;
    end else if (m_halt) begin
      m_have <= 0;
    end else if (m_boot) begin
      m_boot <= 0;
    end else if (!m_have) begin
      if (imem_ready) begin
        m_instr <= imem_rdata;
        m_have  <= 1;
      end
    end else if (!stall_i) begin
      m_have <= 0;
      if (pc_sel && (target_addr % 4) != 0) begin
        m_err  <= 1;
        m_halt <= 1;
      end else begin
        m_pc <= pc_sel ? target_addr : m_pc + 32'd4;
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %08h expected %08h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      cmp("model.imem_req", {31'd0, imem_req},
          {31'd0, rst_n && !m_boot && !m_have && !m_halt});
      cmp("model.imem_addr", imem_addr, m_pc);
      cmp("model.pc_out", pc_out, m_pc);
      cmp("model.pc_plus4", pc_plus4, m_pc + 32'd4);
      cmp("model.instr_valid", {31'd0, instr_valid}, {31'd0, m_have});
      cmp("model.instr_out", instr_out, m_instr);
      cmp("model.misaligned_err", {31'd0, misaligned_err}, {31'd0, m_err});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit st, input bit sel, input logic [31:0] tgt,
                       input bit rdy, input logic [31:0] rd);
    stall_i     = st;
    pc_sel      = sel;
    target_addr = tgt;
    imem_ready  = rdy;
    imem_rdata  = rd;
  endtask

  initial begin
    logic [31:0] r;
    rst_n = 1'b0;
    drive(0, 0, 32'h0, 0, 32'h0);
    tick();
    tick();
    check_en = 1;
    cmp("rst.pc_out", pc_out, 32'h00000000);
    cmp("rst.instr_out", instr_out, 32'h00000013);
    cmp("rst.valid", {31'd0, instr_valid}, 32'd0);
    cmp("rst.req", {31'd0, imem_req}, 32'd0);
    cmp("rst.err", {31'd0, misaligned_err}, 32'd0);

    // Boot and first fetch
    drive(0, 0, 32'h0, 1, 32'h00500093);
    rst_n = 1'b1;
    tick();
    cmp("boot.c2_req", {31'd0, imem_req}, 32'd1);
    cmp("boot.c2_addr", imem_addr, 32'h00000000);
    tick();
    cmp("boot.c3_valid", {31'd0, instr_valid}, 32'd1);
    cmp("boot.c3_instr", instr_out, 32'h00500093);

    // Sequential advance 0 -> 4 -> 8
    drive(0, 0, 32'h0, 0, 32'h0);
    tick();
    cmp("seq.pc4", pc_out, 32'h00000004);
    cmp("seq.valid_drop", {31'd0, instr_valid}, 32'd0);
    drive(0, 0, 32'h0, 1, 32'h00100113);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0);
    tick();
    cmp("seq.addr8", imem_addr, 32'h00000008);

    // Aligned taken target
    drive(0, 0, 32'h0, 1, 32'h00000033);
    tick();
    drive(0, 1, 32'h00000100, 0, 32'h0);
    tick();
    cmp("jmp.addr", imem_addr, 32'h00000100);
    cmp("jmp.err", {31'd0, misaligned_err}, 32'd0);

    // Stall held for three cycles in EXEC
    drive(0, 0, 32'h0, 1, 32'h00208193);
    tick();
    drive(1, 1, 32'h00000444, 1, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("stall.pc", pc_out, 32'h00000100);
      cmp("stall.instr", instr_out, 32'h00208193);
      cmp("stall.valid", {31'd0, instr_valid}, 32'd1);
    end
    drive(0, 0, 32'h0, 0, 32'h0);
    tick();
    cmp("stall.resume_req", {31'd0, imem_req}, 32'd1);
    cmp("stall.resume_addr", imem_addr, 32'h00000104);

    // Memory not ready for four cycles, then a misaligned target
    drive(1, 1, 32'h00000202, 0, 32'hFFFFFFFF);
    for (int i = 0; i < 4; i++) begin
      tick();
      cmp("wait.req", {31'd0, imem_req}, 32'd1);
      cmp("wait.addr", imem_addr, 32'h00000104);
    end
    drive(0, 0, 32'h0, 1, 32'h00000000);
    tick();
    drive(0, 1, 32'h00000102, 0, 32'h0);
    tick();
    cmp("mis.err", {31'd0, misaligned_err}, 32'd1);
    cmp("mis.req", {31'd0, imem_req}, 32'd0);
    cmp("mis.pc_held", pc_out, 32'h00000104);
    drive(0, 0, 32'h0, 1, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("halt.req", {31'd0, imem_req}, 32'd0);
      cmp("halt.valid", {31'd0, instr_valid}, 32'd0);
    end

    // PC wrap, then reset in the middle of a fetch
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(0, 0, 32'h0, 1, 32'h00000093);
    tick();
    tick();
    drive(0, 1, 32'hFFFFFFFC, 1, 32'h00C00513);
    tick();
    cmp("wrap.addr_top", imem_addr, 32'hFFFFFFFC);
    cmp("wrap.plus4", pc_plus4, 32'h00000000);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0);
    tick();
    cmp("wrap.addr0", imem_addr, 32'h00000000);
    cmp("wrap.err", {31'd0, misaligned_err}, 32'd0);
    rst_n = 1'b0;
    #1;
    cmp("midrst.req", {31'd0, imem_req}, 32'd0);
    cmp("midrst.valid", {31'd0, instr_valid}, 32'd0);
    cmp("midrst.instr", instr_out, 32'h00000013);
    cmp("midrst.pc", pc_out, 32'h00000000);
    cmp("midrst.err", {31'd0, misaligned_err}, 32'd0);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 32'h0, 1, 32'hCAFEF00D);
    tick();
    cmp("postrst.valid", {31'd0, instr_valid}, 32'd0);
    cmp("postrst.instr", instr_out, 32'h00000013);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      r = $urandom();
      if ($urandom_range(0, 29) != 0) r[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) r = 32'hFFFFFFFC;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, r,
            $urandom_range(0, 2) != 0, $urandom());
      if ($urandom_range(0, 299) == 0 || (m_halt && $urandom_range(0, 7) == 0)) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    check_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
